pl_scoreboard: RTL and testbench

- Checker stage that consumes the stimulus generator's expected-event strobes (inc_exp, dec_exp) and the parking-lot DUT's increment/decrement strobes and car count.
- Holds a reference model of the lot occupancy and matches expected events against DUT events within a bounded latency window.
- Checks the DUT count after each matched event and accumulates pass/error statistics for the comprehensive testbench.
- Synthesizable, single clock domain. Instantiated beside the DUT at testbench top.

---
 rtl/pl_tb_pkg.sv | 27 ++
 rtl/pl_ref_model.sv | 28 ++
 rtl/pl_scoreboard.sv | 176 +++++++++++++++++
 tb/tb_pl_scoreboard.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_tb_pkg.sv
// Shared types and defaults for the parking-lot scoreboard: FSM states,
// event kinds and error codes.
package pl_tb_pkg;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_STAT_W = 8;
  localparam int TIMER_W    = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_DUT, ST_WAIT_EXP, ST_CHECK} state_t;
  typedef enum logic {EV_INC, EV_DEC} ev_kind_t;
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PROTO    = 3'd1,
    ERR_MISSING  = 3'd2,
    ERR_SPURIOUS = 3'd3,
    ERR_KIND     = 3'd4,
    ERR_OVERRUN  = 3'd5,
    ERR_COUNT    = 3'd6
  } err_code_t;

  // Number of error flags raised in one cycle; each one counts separately.
  function automatic logic [2:0] flag_sum(input logic [6:0] flags);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 7; i++) n = n + {2'b00, flags[i]};
    return n;
  endfunction
endpackage

// File: rtl/pl_ref_model.sv
// Reference occupancy of the lot: one step per matched event, holding or
// wrapping at the ends depending on SATURATE.
module pl_ref_model
  import pl_tb_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             apply,
  input  ev_kind_t         kind,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (apply) begin
      if (kind == EV_INC) begin
        if (count == '1) count <= SATURATE ? count : '0;
        else             count <= count + 1'b1;
      end else begin
        if (count == '0) count <= SATURATE ? count : '1;
        else             count <= count - 1'b1;
      end
    end
  end
endmodule

// File: rtl/pl_scoreboard.sv
// Matches expected-event strobes against DUT strobes within a latency window,
// checks the DUT count one cycle after each match and keeps error statistics.
module pl_scoreboard
  import pl_tb_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WINDOW   = 4,
  parameter bit SATURATE = 1'b1,
  parameter int STAT_W   = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_exp,
  input  logic              dec_exp,
  input  logic              dut_inc,
  input  logic              dut_dec,
  input  logic [CNT_W-1:0]  dut_count,
  output logic [CNT_W-1:0]  exp_count,
  output logic [STAT_W-1:0] match_cnt,
  output logic [STAT_W-1:0] err_cnt,
  output logic              err_pulse,
  output logic [2:0]        err_code,
  output logic              error,
  output state_t            dbg_state
);
  localparam logic [TIMER_W-1:0] WIN = TIMER_W'(WINDOW);

  // Handshake: every strobe is a single-cycle event, sampled on the rising
  // edge; there is no back-pressure, so an event not accepted is an error.
  state_t              state, state_nxt;
  ev_kind_t            kind, kind_nxt, apply_kind, exp_kind, dut_kind;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic                exp_ev, dut_ev, apply, chk_ok;
  logic                e_kind, e_over, e_miss, e_spur, e_cnt;
  logic [6:0]          err_flags;
  logic [2:0]          err_n;
  err_code_t           top_code;
  logic [STAT_W:0]     err_sum;

  assign exp_ev   = inc_exp ^ dec_exp;
  assign dut_ev   = dut_inc ^ dut_dec;
  assign exp_kind = dec_exp ? EV_DEC : EV_INC;
  assign dut_kind = dut_dec ? EV_DEC : EV_INC;
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    kind_nxt   = kind;
    timer_nxt  = timer;
    apply      = 1'b0;
    apply_kind = kind;
    chk_ok     = 1'b0;
    e_kind     = 1'b0;
    e_over     = 1'b0;
    e_miss     = 1'b0;
    e_spur     = 1'b0;
    e_cnt      = 1'b0;
    case (state)
      ST_IDLE, ST_CHECK: begin
        // CHECK also runs the idle rules so back-to-back cars are kept.
        if (state == ST_CHECK) begin
          if (dut_count != exp_count) e_cnt = 1'b1;
          else                        chk_ok = 1'b1;
          state_nxt = ST_IDLE;
        end
        if (exp_ev && dut_ev) begin
          if (exp_kind == dut_kind) begin
            apply      = 1'b1;
            apply_kind = exp_kind;
            state_nxt  = ST_CHECK;
          end else begin
            e_kind = 1'b1;
          end
        end else if (exp_ev) begin
          kind_nxt  = exp_kind;
          timer_nxt = '0;
          state_nxt = ST_WAIT_DUT;
        end else if (dut_ev) begin
          kind_nxt  = dut_kind;
          timer_nxt = '0;
          state_nxt = ST_WAIT_EXP;
        end
      end
      ST_WAIT_DUT: begin
        // timer+1 is the number of cycles since the pending event.
        timer_nxt = timer + 1'b1;
        if (dut_ev) begin
          if (dut_kind == kind) begin
            apply     = 1'b1;
            state_nxt = ST_CHECK;
          end else begin
            e_kind    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (exp_ev) begin
          e_over    = 1'b1;
          kind_nxt  = exp_kind;
          timer_nxt = '0;
        end else if (timer_nxt == WIN) begin
          e_miss    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_EXP: begin
        timer_nxt = timer + 1'b1;
        if (exp_ev) begin
          if (exp_kind == kind) begin
            apply     = 1'b1;
            state_nxt = ST_CHECK;
          end else begin
            e_kind    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (dut_ev) begin
          e_over    = 1'b1;
          kind_nxt  = dut_kind;
          timer_nxt = '0;
        end else if (timer_nxt == WIN) begin
          e_spur    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign err_flags = {e_cnt, e_over, e_kind, e_spur, e_miss,
                      dut_inc & dut_dec, inc_exp & dec_exp};
  assign err_n     = flag_sum(err_flags);
  assign err_sum   = {1'b0, err_cnt} + {{(STAT_W-2){1'b0}}, err_n};

  // Highest code wins when several errors land in the same cycle.
  always_comb begin
    if      (err_flags[6]) top_code = ERR_COUNT;
    else if (err_flags[5]) top_code = ERR_OVERRUN;
    else if (err_flags[4]) top_code = ERR_KIND;
    else if (err_flags[3]) top_code = ERR_SPURIOUS;
    else if (err_flags[2]) top_code = ERR_MISSING;
    else if (err_flags[1] || err_flags[0]) top_code = ERR_PROTO;
    else                   top_code = ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      kind      <= EV_INC;
      timer     <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      kind      <= kind_nxt;
      timer     <= timer_nxt;
      err_pulse <= (err_n != 3'd0);
      if (err_n != 3'd0) begin
        err_code <= top_code;
        error    <= 1'b1;
        err_cnt  <= err_sum[STAT_W] ? '1 : err_sum[STAT_W-1:0];
      end
      if (chk_ok && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
    end
  end

  pl_ref_model #(
    .CNT_W    (CNT_W),
    .SATURATE (SATURATE)
  ) u_model (
    .clk   (clk),
    .reset (reset),
    .apply (apply),
    .kind  (apply_kind),
    .count (exp_count)
  );
endmodule

// File: tb/tb_pl_scoreboard.sv
// Bench for pl_scoreboard: a mock lot counter feeds dut_count, directed
// scenarios follow the plan, then random well-formed scenarios are scored.
`timescale 1ns/1ps
module tb_pl_scoreboard;
  import pl_tb_pkg::*;

  localparam int CNT_W  = 4;
  localparam int STAT_W = 8;
  localparam int WINDOW = 4;
  localparam int CMAX   = 15;
  localparam int SMAX   = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              inc_exp = 1'b0, dec_exp = 1'b0;
  logic              dut_inc = 1'b0, dut_dec = 1'b0;
  logic [CNT_W-1:0]  dut_count;
  logic [CNT_W-1:0]  exp_count, wrap_count;
  logic [STAT_W-1:0] match_cnt, err_cnt, w_match, w_err;
  logic              err_pulse, error, w_pulse, w_error;
  logic [2:0]        err_code, w_code;
  state_t            dbg_state, w_state;

  // ---------------- clock / reset / mock lot counter ----------------
  always #5 clk = ~clk;

  logic [CNT_W-1:0] lot;
  always @(posedge clk) begin
    if (!reset) lot <= '0;
    else if (dut_inc && !dut_dec && lot != '1) lot <= lot + 1'b1;
    else if (dut_dec && !dut_inc && lot != '0) lot <= lot - 1'b1;
  end
  assign dut_count = lot;

  pl_scoreboard #(.CNT_W(CNT_W), .WINDOW(WINDOW), .SATURATE(1'b1), .STAT_W(STAT_W)) u_dut (
    .clk(clk), .reset(reset), .inc_exp(inc_exp), .dec_exp(dec_exp),
    .dut_inc(dut_inc), .dut_dec(dut_dec), .dut_count(dut_count),
    .exp_count(exp_count), .match_cnt(match_cnt), .err_cnt(err_cnt),
    .err_pulse(err_pulse), .err_code(err_code), .error(error), .dbg_state(dbg_state)
  );

  pl_scoreboard #(.CNT_W(CNT_W), .WINDOW(WINDOW), .SATURATE(1'b0), .STAT_W(STAT_W)) u_wrap (
    .clk(clk), .reset(reset), .inc_exp(inc_exp), .dec_exp(dec_exp),
    .dut_inc(dut_inc), .dut_dec(dut_dec), .dut_count(dut_count),
    .exp_count(wrap_count), .match_cnt(w_match), .err_cnt(w_err),
    .err_pulse(w_pulse), .err_code(w_code), .error(w_error), .dbg_state(w_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int m_cnt, m_wrap, m_lot, m_match, m_err, m_code;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int sat_step(input int c, input bit dec);
    if (dec) return (c == 0) ? 0 : c - 1;
    return (c == CMAX) ? CMAX : c + 1;
  endfunction

  function automatic int wrap_step(input int c, input bit dec);
    return dec ? (c + CMAX) % (CMAX + 1) : (c + 1) % (CMAX + 1);
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_wrap = 0; m_lot = 0; m_match = 0; m_err = 0; m_code = 0;
    exp_q.delete();
  endtask

  task automatic note_err(input int code);
    m_err  = (m_err < SMAX) ? m_err + 1 : SMAX;
    m_code = code;
  endtask

  // A matched car: model and mock lot both move; the count check decides.
  task automatic note_match(input bit dec);
    m_cnt  = sat_step(m_cnt, dec);
    m_wrap = wrap_step(m_wrap, dec);
    m_lot  = sat_step(m_lot, dec);
    if (m_lot == m_cnt) m_match = (m_match < SMAX) ? m_match + 1 : SMAX;
    else note_err(6);
    exp_q.push_back(CNT_W'(m_cnt));
  endtask

  task automatic check_all(input string tag);
    logic [CNT_W-1:0] q_cnt;
    q_cnt = CNT_W'(m_cnt);
    while (exp_q.size() > 0) q_cnt = exp_q.pop_front();
    check({tag, ".exp_count"}, 32'(exp_count), 32'(q_cnt));
    check({tag, ".wrap_count"}, 32'(wrap_count), m_wrap);
    check({tag, ".match_cnt"}, 32'(match_cnt), m_match);
    check({tag, ".err_cnt"}, 32'(err_cnt), m_err);
    check({tag, ".err_code"}, 32'(err_code), m_code);
    check({tag, ".error"}, 32'(error), 32'(m_err > 0));
    check({tag, ".err_pulse"}, 32'(err_pulse), 0);
    check({tag, ".state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ie, input logic de, input logic di, input logic dd);
    inc_exp = ie; dec_exp = de; dut_inc = di; dut_dec = dd;
    @(negedge clk);
    inc_exp = 1'b0; dec_exp = 1'b0; dut_inc = 1'b0; dut_dec = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    model_clear();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  mode, d;
    bit  k;

    model_clear();
    do_reset();
    check_all("reset");

    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1, 0);
      note_match(1'b0);
    end
    idle(2);
    check_all("inc9");

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      idle(1);
      drive(0, 0, 0, 1);
      note_match(1'b1);
    end
    idle(2);
    check_all("dec3_lag2");

    drive(1, 0, 0, 0);
    idle(3);
    check("missing.pulse_early", 32'(err_pulse), 0);
    idle(1);
    check("missing.pulse", 32'(err_pulse), 1);
    idle(1);
    check("missing.pulse_drop", 32'(err_pulse), 0);
    note_err(2);
    check_all("missing");

    drive(0, 0, 0, 1);
    m_lot = sat_step(m_lot, 1'b1);
    note_err(3);
    idle(WINDOW + 2);
    check_all("spurious");

    drive(1, 0, 1, 0);
    drive(1, 1, 0, 0);
    check("count_proto.pulse", 32'(err_pulse), 1);
    note_match(1'b0);
    note_err(1);
    m_code = 6;
    idle(2);
    check_all("count_proto");

    drive(1, 0, 0, 0);
    idle(1);
    reset = 1'b0;
    drive(1, 0, 1, 0);
    reset = 1'b1;
    model_clear();
    idle(WINDOW + 2);
    check_all("reset_mid_wait");

    for (int i = 0; i < 18; i++) begin
      drive(1, 0, 1, 0);
      note_match(1'b0);
    end
    idle(2);
    check_all("inc18_sat");
    check("inc18.exp_count_const", 32'(exp_count), 15);
    check("inc18.wrap_count_const", 32'(wrap_count), 2);

    drive(1, 1, 0, 0);
    note_err(1);
    idle(2);
    check_all("proto");

    drive(1, 0, 0, 1);
    m_lot = sat_step(m_lot, 1'b1);
    note_err(4);
    idle(2);
    check_all("kind");

    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    idle(1);
    drive(0, 0, 1, 0);
    note_err(5);
    note_match(1'b0);
    idle(2);
    check_all("overrun");

    drive(0, 1, 0, 0);
    idle(WINDOW - 1);
    drive(0, 0, 0, 1);
    note_match(1'b1);
    idle(2);
    check_all("lag_window_edge");

    do_reset();
    for (int s = 0; s < 60; s++) begin
      mode = $urandom_range(0, 8);
      if (mode > 5) mode = 0;
      k = 1'($urandom_range(0, 1));
      d = $urandom_range(1, WINDOW);
      case (mode)
        0: begin
          drive(!k, k, !k, k);
          note_match(k);
        end
        1: begin
          drive(!k, k, 0, 0);
          idle(d - 1);
          drive(0, 0, !k, k);
          note_match(k);
        end
        2: begin
          drive(0, 0, !k, k);
          idle(d - 1);
          drive(!k, k, 0, 0);
          note_match(k);
        end
        3: begin
          drive(!k, k, 0, 0);
          note_err(2);
        end
        4: begin
          drive(0, 0, !k, k);
          m_lot = sat_step(m_lot, k);
          note_err(3);
        end
        default: begin
          if (k) drive(0, 0, 1, 1);
          else   drive(1, 1, 0, 0);
          note_err(1);
        end
      endcase
      idle(WINDOW + 3);
      check_all($sformatf("rand%0d_m%0d", s, mode));
    end

    do_reset();
    for (int i = 0; i < 127; i++) begin
      drive(1, 1, 1, 1);
      note_err(1);
      note_err(1);
    end
    idle(2);
    check_all("errsat_254");
    drive(1, 1, 1, 1);
    note_err(1);
    note_err(1);
    idle(2);
    check_all("errsat_255");
    drive(1, 1, 1, 1);
    note_err(1);
    note_err(1);
    idle(2);
    check_all("errsat_hold");
    check("errsat.const", 32'(err_cnt), 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
